uart_baud_gen: RTL and testbench

Parametrised baud-tick generator for the UART transmitter and receiver. It produces an oversampled tick (os_tick) and a bit-rate tick (bit_tick) from a runtime-programmable integer-plus-fractional divisor, replacing fixed compile-time division. It sits between the APB register block, which supplies the divisor, and the UART tx/rx engines, which consume the ticks.

---
 rtl/uart_baud_gen.sv | 147 ++++++++++++++
 tb/tb_uart_baud_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_gen.sv
// Baud-tick generator: programmable integer + fractional divisor producing
// an oversample tick and a bit tick for the UART tx/rx engines.
module uart_baud_gen #(
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned FRAC_WIDTH = 4,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned RESET_DIV  = 27,
    parameter int unsigned RESET_FRAC = 2,
    localparam int unsigned PHASE_W   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  div_load,
    input  logic [DIV_WIDTH-1:0]  div_int,
    input  logic [FRAC_WIDTH-1:0] div_frac,
    input  logic                  tx_sync,
    output logic                  os_tick,
    output logic                  bit_tick,
    output logic [PHASE_W-1:0]    bit_phase,
    output logic                  active
);

    localparam logic [PHASE_W-1:0]    PHASE_MAX  = PHASE_W'(OVERSAMPLE - 1);
    localparam logic [DIV_WIDTH-1:0]  INIT_DIV   = DIV_WIDTH'(RESET_DIV);
    localparam logic [FRAC_WIDTH-1:0] INIT_FRAC  = FRAC_WIDTH'(RESET_FRAC);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DIV_WIDTH-1:0]  shadow_div;
    logic [DIV_WIDTH-1:0]  active_div;
    logic [DIV_WIDTH-1:0]  cnt;
    logic [FRAC_WIDTH-1:0] shadow_frac;
    logic [FRAC_WIDTH-1:0] active_frac;
    logic [FRAC_WIDTH-1:0] acc;
    logic                  carry;
    logic                  load_pend;
    logic [PHASE_W-1:0]    phase;
    logic                  os_tick_q;
    logic                  bit_tick_q;
    logic                  active_q;

    logic [DIV_WIDTH:0]    period_m1;
    logic [FRAC_WIDTH:0]   frac_sum;
    logic                  terminal;
    logic                  phase_clear;
    logic                  tick_now;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= (state_d == RUN);
        end
    end

    // A zero divisor means halt, so it both blocks entry to RUN and forces exit.
    always_comb begin
        state_d     = state_q;
        period_m1   = '0;
        frac_sum    = '0;
        terminal    = 1'b0;
        phase_clear = 1'b0;
        tick_now    = 1'b0;

        case (state_q)
            IDLE: if (enable && (active_div != '0)) state_d = RUN;
            RUN:  if (!enable || (active_div == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        period_m1   = {1'b0, active_div} + {{DIV_WIDTH{1'b0}}, carry}
                      - {{DIV_WIDTH{1'b0}}, 1'b1};
        frac_sum    = {1'b0, acc} + {1'b0, active_frac};
        terminal    = (state_q == RUN) && ({1'b0, cnt} == period_m1);
        phase_clear = (state_d != state_q) || ((state_q == RUN) && tx_sync);
        tick_now    = terminal && !phase_clear;
    end

    // Divisor shadowing: IDLE takes new values at once, RUN defers them to an os_tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_div  <= INIT_DIV;
            shadow_frac <= INIT_FRAC;
            active_div  <= INIT_DIV;
            active_frac <= INIT_FRAC;
            load_pend   <= 1'b0;
        end else begin
            if (div_load) begin
                shadow_div  <= div_int;
                shadow_frac <= div_frac;
            end
            if (state_q == IDLE) begin
                active_div  <= div_load ? div_int  : shadow_div;
                active_frac <= div_load ? div_frac : shadow_frac;
                load_pend   <= 1'b0;
            end else begin
                if (tick_now && load_pend) begin
                    active_div  <= shadow_div;
                    active_frac <= shadow_frac;
                end
                load_pend <= div_load || (load_pend && !tick_now);
            end
        end
    end

    // Period counter, fractional accumulator and bit phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            acc        <= '0;
            carry      <= 1'b0;
            phase      <= '0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            os_tick_q  <= tick_now;
            bit_tick_q <= tick_now && (phase == PHASE_MAX);
            if (phase_clear) begin
                cnt   <= '0;
                acc   <= '0;
                carry <= 1'b0;
                phase <= '0;
            end else if (tick_now) begin
                cnt          <= '0;
                {carry, acc} <= frac_sum;
                phase        <= (phase == PHASE_MAX) ? '0 : phase + 1'b1;
            end else if (state_q == RUN) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign os_tick   = os_tick_q;
    assign bit_tick  = bit_tick_q;
    assign bit_phase = phase;
    assign active    = active_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed self-checking bench for uart_baud_gen: tick timing, fractional
// carry, divisor reload, tx_sync, halt, disable and async reset.
module tb_uart_baud_gen;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        div_load;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        tx_sync;
    logic        os_tick;
    logic        bit_tick;
    logic [3:0]  bit_phase;
    logic        active;

    int pass_count = 0;
    int check_count = 0;
    int per [1:72];
    int n;
    int sum;
    int ticks;
    int bits;

    uart_baud_gen dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .div_load  (div_load),
        .div_int   (div_int),
        .div_frac  (div_frac),
        .tx_sync   (tx_sync),
        .os_tick   (os_tick),
        .bit_tick  (bit_tick),
        .bit_phase (bit_phase),
        .active    (active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        if (observed == expected) pass_count++;
        else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    endtask

    // Drive inputs now, let the next rising edge sample them, then drop the pulses.
    task automatic applyStimulus(input logic en, input logic ld, input logic [15:0] di,
                                 input logic [3:0] df, input logic sync);
        enable   = en;
        div_load = ld;
        div_int  = di;
        div_frac = df;
        tx_sync  = sync;
        @(posedge clk);
        #1;
        div_load = 1'b0;
        tx_sync  = 1'b0;
    endtask

    // Rising edges until os_tick is seen high; -1 if none within the budget.
    task automatic waitTick(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (os_tick) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic countTicks(input int cycles, output int t, output int b);
        t = 0;
        b = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (os_tick) t++;
            if (bit_tick) b++;
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        div_load = 1'b0;
        div_int  = '0;
        div_frac = '0;
        tx_sync  = 1'b0;

        #23;
        checkOutput("reset_os_tick", os_tick, 0);
        checkOutput("reset_bit_tick", bit_tick, 0);
        checkOutput("reset_bit_phase", bit_phase, 0);
        checkOutput("reset_active", active, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // D=27 F=0: 27-cycle periods, bit_tick on the 16th os_tick
        applyStimulus(0, 1, 16'd27, 4'd0, 0);
        applyStimulus(1, 0, 16'd0, 4'd0, 0);
        checkOutput("run_active", active, 1);
        sum = 0;
        for (int k = 1; k <= 16; k++) begin
            waitTick(n);
            if (n < 0) break;
            per[k] = n;
            sum += n;
            if (k == 1) checkOutput("first_phase", bit_phase, 1);
            if (k == 15) checkOutput("bit_tick_15", bit_tick, 0);
        end
        checkOutput("first_latency", per[1], 27);
        checkOutput("period_2", per[2], 27);
        checkOutput("bit_tick_16", bit_tick, 1);
        checkOutput("phase_wrap", bit_phase, 0);
        checkOutput("bit_period_sum", sum, 432);

        // D=27 F=2: every 8th period is 28 cycles
        applyStimulus(0, 0, 16'd0, 4'd0, 0);
        @(negedge clk);
        checkOutput("idle_active", active, 0);
        applyStimulus(0, 1, 16'd27, 4'd2, 0);
        applyStimulus(1, 0, 16'd0, 4'd0, 0);
        for (int k = 1; k <= 72; k++) per[k] = 0;
        for (int k = 1; k <= 72; k++) begin
            waitTick(n);
            if (n < 0) break;
            per[k] = n;
        end
        sum = 0;
        for (int k = 9; k <= 72; k++) sum += per[k];
        checkOutput("frac_period_8", per[8], 27);
        checkOutput("frac_period_9", per[9], 28);
        checkOutput("frac_period_10", per[10], 27);
        checkOutput("frac_period_17", per[17], 28);
        checkOutput("frac_span_8_72", sum, 1736);

        // Reload D=10 mid-period while running D=27
        applyStimulus(0, 0, 16'd0, 4'd0, 0);
        applyStimulus(0, 1, 16'd27, 4'd0, 0);
        applyStimulus(1, 0, 16'd0, 4'd0, 0);
        waitTick(n);
        checkOutput("reload_first", n, 27);
        applyStimulus(1, 1, 16'd10, 4'd0, 0);
        waitTick(n);
        checkOutput("reload_current_rest", n, 26);
        waitTick(n);
        checkOutput("reload_new_period", n, 10);
        waitTick(n);
        checkOutput("reload_new_period_2", n, 10);

        // tx_sync coinciding with the terminal count at bit_phase 7
        applyStimulus(0, 0, 16'd0, 4'd0, 0);
        applyStimulus(0, 1, 16'd27, 4'd0, 0);
        applyStimulus(1, 0, 16'd0, 4'd0, 0);
        for (int k = 1; k <= 7; k++) begin
            waitTick(n);
            if (n < 0) break;
        end
        checkOutput("sync_pre_phase", bit_phase, 7);
        repeat (26) @(posedge clk);
        #1;
        applyStimulus(1, 0, 16'd0, 4'd0, 1);
        @(negedge clk);
        checkOutput("sync_tick_suppressed", os_tick, 0);
        checkOutput("sync_phase_cleared", bit_phase, 0);
        waitTick(n);
        checkOutput("sync_next_tick", n, 27);
        checkOutput("sync_phase_after", bit_phase, 1);

        // D=0 halts; D=1 ticks every cycle
        applyStimulus(0, 0, 16'd0, 4'd0, 0);
        applyStimulus(0, 1, 16'd0, 4'd0, 0);
        applyStimulus(1, 0, 16'd0, 4'd0, 0);
        countTicks(40, ticks, bits);
        checkOutput("halt_ticks", ticks, 0);
        checkOutput("halt_active", active, 0);
        applyStimulus(1, 1, 16'd1, 4'd0, 0);
        waitTick(n);
        checkOutput("div1_first", n, 2);
        countTicks(48, ticks, bits);
        checkOutput("div1_os_ticks", ticks, 48);
        checkOutput("div1_bit_ticks", bits, 3);

        // Disable at bit_phase 5, then restart
        applyStimulus(0, 0, 16'd0, 4'd0, 0);
        applyStimulus(0, 1, 16'd27, 4'd0, 0);
        applyStimulus(1, 0, 16'd0, 4'd0, 0);
        for (int k = 1; k <= 5; k++) begin
            waitTick(n);
            if (n < 0) break;
        end
        checkOutput("dis_pre_phase", bit_phase, 5);
        applyStimulus(0, 0, 16'd0, 4'd0, 0);
        @(negedge clk);
        checkOutput("dis_active", active, 0);
        checkOutput("dis_phase", bit_phase, 0);
        countTicks(40, ticks, bits);
        checkOutput("dis_no_ticks", ticks, 0);
        applyStimulus(1, 0, 16'd0, 4'd0, 0);
        waitTick(n);
        checkOutput("reenable_first", n, 27);

        // Async reset while os_tick is high; defaults D=27 F=2 return
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        checkOutput("async_os_tick", os_tick, 0);
        checkOutput("async_active", active, 0);
        checkOutput("async_phase", bit_phase, 0);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1, 0, 16'd0, 4'd0, 0);
        for (int k = 1; k <= 9; k++) per[k] = 0;
        for (int k = 1; k <= 9; k++) begin
            waitTick(n);
            if (n < 0) break;
            per[k] = n;
        end
        checkOutput("post_reset_first", per[1], 27);
        checkOutput("post_reset_period_9", per[9], 28);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
